// File: rtl/display_sync_fifo.sv
// Single-clock display-path FIFO: registered-read RAM, usedw counter, flags and sticky errors.
// Define DISPLAY_FIFO_SHOWAHEAD_EN for show-ahead mode (head word on q through a prefetch stage).
module display_sync_fifo #(
  parameter int DATA_BITS   = 41,
  parameter int ADDR_BITS   = 4,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 wrreq,
  input  logic                 rdreq,
  output logic [DATA_BITS-1:0] q,
  output logic                 q_valid,
  output logic [ADDR_BITS:0]   usedw,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_full,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int               DEPTH   = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] DEPTH_W = (ADDR_BITS+1)'(DEPTH);
  localparam logic [ADDR_BITS:0] AFULL_W = (ADDR_BITS+1)'(AFULL_LEVEL);
  localparam logic [ADDR_BITS:0] ONE_W   = (ADDR_BITS+1)'(1);
  localparam logic [ADDR_BITS-1:0] ONE_P = ADDR_BITS'(1);

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr, rd_ptr;
  logic                 wr_acc, rd_acc;
  logic [ADDR_BITS:0]   usedw_nxt;

`ifdef DISPLAY_FIFO_SHOWAHEAD_EN
  // Words sit in RAM, then the RAM read register (s1), then q; usedw counts all three.
  logic [ADDR_BITS:0]   ram_cnt, ram_cnt_nxt;
  logic [DATA_BITS-1:0] s1_data;
  logic                 s1_valid, s1_load, q_load;
`endif

  always_comb begin
    wr_acc    = 1'b0;
    rd_acc    = 1'b0;
    usedw_nxt = usedw;
    if (reset_n && !flush) begin
`ifdef DISPLAY_FIFO_SHOWAHEAD_EN
      rd_acc = rdreq && q_valid;
`else
      rd_acc = rdreq && !empty;
`endif
      wr_acc = wrreq && (!full || rd_acc);
    end
    case ({wr_acc, rd_acc})
      2'b10:   usedw_nxt = usedw + ONE_W;
      2'b01:   usedw_nxt = usedw - ONE_W;
      default: usedw_nxt = usedw;
    endcase
  end

`ifdef DISPLAY_FIFO_SHOWAHEAD_EN
  always_comb begin
    q_load      = s1_valid && (!q_valid || rd_acc);
    s1_load     = reset_n && !flush && (ram_cnt != '0) && (!s1_valid || q_load);
    ram_cnt_nxt = ram_cnt;
    case ({wr_acc, s1_load})
      2'b10:   ram_cnt_nxt = ram_cnt + ONE_W;
      2'b01:   ram_cnt_nxt = ram_cnt - ONE_W;
      default: ram_cnt_nxt = ram_cnt;
    endcase
  end
`endif

  // RAM write port kept free of reset so it maps onto block memory.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      usedw       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      q           <= '0;
      q_valid     <= 1'b0;
`ifdef DISPLAY_FIFO_SHOWAHEAD_EN
      ram_cnt     <= '0;
      s1_data     <= '0;
      s1_valid    <= 1'b0;
`endif
    end else if (flush) begin
      // q deliberately keeps its last value across a flush.
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      usedw       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      q_valid     <= 1'b0;
`ifdef DISPLAY_FIFO_SHOWAHEAD_EN
      ram_cnt     <= '0;
      s1_valid    <= 1'b0;
`endif
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ONE_P;
      usedw       <= usedw_nxt;
      empty       <= (usedw_nxt == '0);
      full        <= (usedw_nxt == DEPTH_W);
      almost_full <= (usedw_nxt >= AFULL_W);
      if (wrreq && !wr_acc) overflow  <= 1'b1;
      if (rdreq && !rd_acc) underflow <= 1'b1;
`ifdef DISPLAY_FIFO_SHOWAHEAD_EN
      ram_cnt <= ram_cnt_nxt;
      if (s1_load) begin
        s1_data  <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + ONE_P;
        s1_valid <= 1'b1;
      end else if (q_load) begin
        s1_valid <= 1'b0;
      end
      if (q_load) begin
        q       <= s1_data;
        q_valid <= 1'b1;
      end else if (rd_acc) begin
        q_valid <= 1'b0;
      end
`else
      // Read-before-write: a full-FIFO read+write at the same address sees the old word.
      if (rd_acc) begin
        q      <= mem[rd_ptr];
        rd_ptr <= rd_ptr + ONE_P;
      end
      q_valid <= rd_acc;
`endif
    end
  end

endmodule

// File: tb/tb_display_sync_fifo.sv
// Directed bench for display_sync_fifo (depth 4, almost_full at 3): vector table plus hand sequences.
module tb_display_sync_fifo;
  localparam int DW = 41;

  logic          clk = 1'b0;
  logic          reset_n, flush, wrreq, rdreq;
  logic [DW-1:0] data;
  logic [DW-1:0] q;
  logic          q_valid, empty, full, almost_full, overflow, underflow;
  logic [2:0]    usedw;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic          rst_n, fl, wr, rd;
    logic [DW-1:0] d;
    logic          qv;
    logic [DW-1:0] eq;
    logic [2:0]    uw;
    logic          e, f, af, ov, un;
  } vec_t;
  vec_t vecs[$];

  display_sync_fifo #(.DATA_BITS(DW), .ADDR_BITS(2), .AFULL_LEVEL(3)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .data(data), .wrreq(wrreq), .rdreq(rdreq),
    .q(q), .q_valid(q_valid), .usedw(usedw), .empty(empty), .full(full),
    .almost_full(almost_full), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic v(input logic n, fl, w, r, input logic [DW-1:0] d, input logic qv,
                   input logic [DW-1:0] eq, input int uw, input logic e, f, af, ov, un);
    vec_t t;
    t = '{n, fl, w, r, d, qv, eq, 3'(uw), e, f, af, ov, un};
    vecs.push_back(t);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; wrreq = 1'b0; rdreq = 1'b0; data = '0; reset_n = 1'b1;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    wrreq = 1'b1; data = d;
    step();
    wrreq = 1'b0;
    exp_q.push_back(d);
  endtask

  task automatic pop_check(input string nm);
    logic [DW-1:0] e;
    rdreq = 1'b1;
    step();
    rdreq = 1'b0;
    chk({nm, " q_valid"}, DW'(q_valid), DW'(1));
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: got extra read expected none", nm);
    end else begin
      e = exp_q.pop_front();
      chk({nm, " q"}, q, e);
    end
  endtask

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    step(); step();
    chk("reset usedw", DW'(usedw), DW'(0));
    chk("reset empty", DW'(empty), DW'(1));
    chk("reset full", DW'(full), DW'(0));
    chk("reset almost_full", DW'(almost_full), DW'(0));
    chk("reset q", q, '0);
    chk("reset q_valid", DW'(q_valid), DW'(0));
    chk("reset overflow", DW'(overflow), DW'(0));
    chk("reset underflow", DW'(underflow), DW'(0));
    reset_n = 1'b1;

`ifndef DISPLAY_FIFO_SHOWAHEAD_EN
    // rst_n fl wr rd data | qv q usedw e f af ov un
    v(1,0,1,0,'h1,  0,'h0,  1,0,0,0,0,0);   // fill
    v(1,0,1,0,'h2,  0,'h0,  2,0,0,0,0,0);
    v(1,0,1,0,'h3,  0,'h0,  3,0,0,1,0,0);
    v(1,0,1,0,'h4,  0,'h0,  4,0,1,1,0,0);
    v(1,0,1,0,'h5,  0,'h0,  4,0,1,1,1,0);   // overflow, write dropped
    v(1,0,0,1,'h0,  1,'h1,  3,0,0,1,1,0);   // drain
    v(1,0,0,1,'h0,  1,'h2,  2,0,0,0,1,0);
    v(1,0,0,0,'h0,  0,'h2,  2,0,0,0,1,0);   // q holds, pulse ends
    v(1,0,0,1,'h0,  1,'h3,  1,0,0,0,1,0);
    v(1,0,0,1,'h0,  1,'h4,  0,1,0,0,1,0);
    v(1,0,0,1,'h0,  0,'h4,  0,1,0,0,1,1);   // underflow
    v(1,0,1,1,'hA,  0,'h4,  1,0,0,0,1,1);   // empty + both: write only
    v(1,0,0,1,'h0,  1,'hA,  0,1,0,0,1,1);
    v(1,1,0,0,'h0,  0,'hA,  0,1,0,0,0,0);   // flush clears sticky flags
    v(1,0,1,0,'h11, 0,'hA,  1,0,0,0,0,0);
    v(1,0,1,0,'h12, 0,'hA,  2,0,0,0,0,0);
    v(1,0,1,0,'h13, 0,'hA,  3,0,0,1,0,0);
    v(1,0,1,0,'h14, 0,'hA,  4,0,1,1,0,0);
    for (int i = 0; i < 6; i++) begin     // full + both, across pointer wrap
      logic [DW-1:0] eq;
      eq = (i < 4) ? DW'('h11 + i) : DW'('h90 + i - 4);
      v(1,0,1,1,DW'('h90 + i), 1, eq, 4,0,1,1,0,0);
    end
    v(1,0,0,1,'h0,  1,'h92, 3,0,0,1,0,0);
    v(1,0,0,1,'h0,  1,'h93, 2,0,0,0,0,0);
    v(1,0,0,1,'h0,  1,'h94, 1,0,0,0,0,0);
    v(1,0,0,1,'h0,  1,'h95, 0,1,0,0,0,0);
    v(1,0,0,1,'h0,  0,'h95, 0,1,0,0,0,1);
    v(1,0,1,0,'h21, 0,'h95, 1,0,0,0,0,1);
    v(1,0,1,0,'h22, 0,'h95, 2,0,0,0,0,1);
    v(1,0,1,0,'h23, 0,'h95, 3,0,0,1,0,1);
    v(1,1,1,1,'h24, 0,'h95, 0,1,0,0,0,0);   // flush beats write and read
    v(1,0,0,1,'h0,  0,'h95, 0,1,0,0,0,1);   // nothing survived the flush
    v(1,0,1,0,'h31, 0,'h95, 1,0,0,0,0,1);
    v(1,0,1,0,'h32, 0,'h95, 2,0,0,0,0,1);
    v(1,0,1,0,'h33, 0,'h95, 3,0,0,1,0,1);
    v(0,0,1,1,'h34, 0,'h0,  0,1,0,0,0,0);   // reset beats write and read
    v(1,0,0,0,'h0,  0,'h0,  0,1,0,0,0,0);   // no late q_valid pulse

    for (int i = 0; i < vecs.size(); i++) begin
      string p;
      p = $sformatf("v%0d", i);
      reset_n = vecs[i].rst_n; flush = vecs[i].fl;
      wrreq = vecs[i].wr; rdreq = vecs[i].rd; data = vecs[i].d;
      step();
      chk({p, " q_valid"}, DW'(q_valid), DW'(vecs[i].qv));
      chk({p, " q"}, q, vecs[i].eq);
      chk({p, " usedw"}, DW'(usedw), DW'(vecs[i].uw));
      chk({p, " empty"}, DW'(empty), DW'(vecs[i].e));
      chk({p, " full"}, DW'(full), DW'(vecs[i].f));
      chk({p, " almost_full"}, DW'(almost_full), DW'(vecs[i].af));
      chk({p, " overflow"}, DW'(overflow), DW'(vecs[i].ov));
      chk({p, " underflow"}, DW'(underflow), DW'(vecs[i].un));
    end
    idle_inputs();

    // Wide-data stream through the scoreboard, with an interleaved idle cycle.
    push_word(41'h1_FFFF_FFFF_FF);
    push_word(41'h0_0000_0000_01);
    push_word(41'h1_5555_5555_55);
    pop_check("sb0");
    push_word(41'h0_AAAA_AAAA_AA);
    step();
    chk("sb idle q_valid", DW'(q_valid), DW'(0));
    pop_check("sb1");
    pop_check("sb2");
    pop_check("sb3");
    chk("sb empty", DW'(empty), DW'(1));
    chk("sb leftovers", DW'(exp_q.size()), DW'(0));
`else
    wrreq = 1'b1; data = 'h7;
    step();
    wrreq = 1'b0;
    chk("sa write edge q_valid", DW'(q_valid), DW'(0));
    chk("sa write edge usedw", DW'(usedw), DW'(1));
    step();
    chk("sa +1 q_valid", DW'(q_valid), DW'(0));
    step();
    chk("sa +2 q_valid", DW'(q_valid), DW'(1));
    chk("sa +2 q", q, 'h7);
    wrreq = 1'b1; data = 'h8;
    step();
    wrreq = 1'b0;
    step(); step();
    chk("sa usedw 2", DW'(usedw), DW'(2));
    chk("sa head held", q, 'h7);
    rdreq = 1'b1;
    step();
    chk("sa pop q", q, 'h8);
    chk("sa pop q_valid", DW'(q_valid), DW'(1));
    chk("sa pop usedw", DW'(usedw), DW'(1));
    step();
    rdreq = 1'b0;
    chk("sa last q_valid", DW'(q_valid), DW'(0));
    chk("sa last empty", DW'(empty), DW'(1));
    chk("sa underflow clear", DW'(underflow), DW'(0));
    rdreq = 1'b1;
    step();
    rdreq = 1'b0;
    chk("sa underflow", DW'(underflow), DW'(1));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/display_sync_fifo.md
Name: display_sync_fifo

Overview:
Parametrised single-clock FIFO for the display path. It replaces the fixed-address RAM stub with real read/write pointers, occupancy tracking, full/empty/almost-full flags and sticky error flags. It buffers pixel/control words between the frame-store read engine and the display output formatter. Storage is a simple dual-port RAM with one write port and one registered read port, both on the same clock.

Parameters:
DATA_BITS, 41, word width in bits.
ADDR_BITS, 4, log2 of depth; depth = 2**ADDR_BITS.
AFULL_LEVEL, 12, almost_full asserts when usedw >= AFULL_LEVEL; legal range 1..depth.

Ports:
clk  input  1  single clock; all logic is rising-edge.
reset_n  input  1  synchronous active-low reset.
flush  input  1  synchronous clear of FIFO contents, active-high.
data  input  DATA_BITS  write data.
wrreq  input  1  write request.
rdreq  input  1  read request.
q  output  DATA_BITS  read data.
q_valid  output  1  q holds a newly read word (see Behaviour / Optional Feature).
usedw  output  ADDR_BITS+1  number of words stored, 0..depth.
empty  output  1  usedw == 0.
full  output  1  usedw == depth.
almost_full  output  1  usedw >= AFULL_LEVEL.
overflow  output  1  sticky: a write was rejected.
underflow  output  1  sticky: a read was rejected.

Behaviour:
- Interface as decided: one clock, clk; reset_n is synchronous and active-low.
- Reset (reset_n=0 at clk edge): pointers=0, usedw=0, empty=1, full=0, almost_full=0, q=0, q_valid=0, overflow=0, underflow=0. RAM contents are not cleared.
- Pointers are ADDR_BITS wide and wrap naturally from depth-1 to 0. usedw is kept as a separate registered counter.
- Accepted write: wrreq && (!full || rd_acc). Writes data at wr_ptr, then wr_ptr+1.
- Accepted read: rdreq && !empty. Reads from rd_ptr, then rd_ptr+1.
- usedw next value: +1 on write only, -1 on read only, unchanged on both or neither.
- All flags are registered and derived from next-state usedw, so they are correct in the cycle after the access.
- Default read timing: q is updated one cycle after an accepted rdreq, and q_valid pulses high for exactly that cycle. Otherwise q holds its last value and q_valid=0.
- Full with wrreq && rdreq: both are accepted, usedw stays at depth, and full stays 1.
- Full with wrreq only: the write is dropped, contents are unchanged, and overflow is set to 1.
- Empty with wrreq && rdreq: the write is accepted, the read is rejected, and underflow is set to 1. There is no write-through.
- Empty with rdreq only: rejected, underflow set to 1, q unchanged, q_valid=0.
- overflow and underflow stay set until reset_n=0 or flush=1.
- flush=1: same-cycle wrreq and rdreq are ignored. Pointers, usedw, q_valid and the sticky flags are cleared; empty=1 next cycle; q keeps its value.
- Priority: reset_n over flush over wrreq/rdreq.
- Reset or flush mid-stream discards all stored words. No in-flight q_valid pulse is produced after the clearing edge.

Optional Feature:
DISPLAY_FIFO_SHOWAHEAD_EN.
- Defined: show-ahead mode. q always presents the head word while the FIFO is non-empty, and q_valid is a level equal to "head word present".
  - rdreq pops the head; the next word appears on q in the following cycle with no bubble.
  - A write into an empty FIFO makes q_valid=1 two cycles after the write edge, via an internal prefetch register.
  - usedw counts the prefetched word.
  - Empty with wrreq && rdreq: behaves as in default mode (read rejected, underflow set).
- Undefined: default registered-read mode as described under Behaviour, with no prefetch register.

Test Plan:
- Fill/drain (ADDR_BITS=2, AFULL_LEVEL=3): write 0x1,0x2,0x3,0x4 on consecutive cycles -> usedw 1,2,3,4; almost_full=1 after the third write; full=1 after the fourth. Then 4 reads -> q=0x1..0x4, each one cycle after its rdreq, with one q_valid pulse each; empty=1 at the end.
- Overflow: full FIFO, wrreq with 0x5 alone -> overflow=1, usedw=4. Drain -> 0x1..0x4 only; overflow stays 1 until flush.
- Underflow and empty-simultaneous: empty FIFO, rdreq -> underflow=1, q_valid=0. Then wrreq 0xA with rdreq -> usedw=1, no q_valid; next read returns 0xA.
- Full-simultaneous and wrap: full FIFO, wrreq 0x9 with rdreq for 6 cycles -> usedw stays 4, full stays 1, output order is preserved across pointer wrap.
- Flush/reset mid-operation: 3 words stored, flush asserted together with wrreq -> usedw=0, empty=1, sticky flags=0, write dropped. Repeat with reset_n=0 -> q=0 as well.
- With DISPLAY_FIFO_SHOWAHEAD_EN: write 0x7 into an empty FIFO -> q=0x7 and q_valid=1 two cycles later with no rdreq. Write 0x8, then rdreq -> q=0x8 the next cycle, q_valid stays 1.
